lamp_bus_master: RTL and testbench

Parallel-bus cycle engine between the UART command parser and the lamp-board bus pins. Accepts one read or write command at a time over a valid/ready handshake, then drives the address, data, test-address, RD and WR pins through a programmable setup/strobe/hold sequence. Reports completion with a one-cycle response pulse that carries the read data. The top level instantiates it in place of driving the bus pins directly from the command state machine.

---
 rtl/lamp_bus_pkg.sv | 25 ++
 rtl/lamp_bus_master.sv | 156 +++++++++++++++
 tb/tb_lamp_bus_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/lamp_bus_pkg.sv
// Shared types and constants for the lamp-board parallel bus cycle engine.
package lamp_bus_pkg;

  localparam int LAMP_ADDR_W = 3;
  localparam int LAMP_DATA_W = 8;

  localparam int LAMP_SETUP_DEFAULT  = 2;
  localparam int LAMP_STROBE_DEFAULT = 4;
  localparam int LAMP_HOLD_DEFAULT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } lamp_bus_state_t;

  function automatic int lamp_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lamp_bus_master.sv
// Parallel-bus cycle engine: one read/write command at a time, driven through
// programmable setup/strobe/hold phases, completed by a one-cycle response pulse.
module lamp_bus_master
  import lamp_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = LAMP_SETUP_DEFAULT,
  parameter int STROBE_CYCLES = LAMP_STROBE_DEFAULT,
  parameter int HOLD_CYCLES   = LAMP_HOLD_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [LAMP_ADDR_W-1:0] cmd_addr,
  input  logic                   cmd_test_addr,
  input  logic [LAMP_DATA_W-1:0] cmd_data,
  output logic                   rsp_valid,
  output logic [LAMP_DATA_W-1:0] rsp_data,
  output logic [LAMP_DATA_W-1:0] bus_data_out,
  output logic                   bus_data_oe,
  input  logic [LAMP_DATA_W-1:0] bus_data_in,
  output logic [LAMP_ADDR_W-1:0] bus_addr,
  output logic                   bus_test_addr,
  output logic                   bus_rd,
  output logic                   bus_wr
);

  localparam int MAX_CYCLES = lamp_max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  if (SETUP_CYCLES  < 1 || SETUP_CYCLES  > 255 ||
      STROBE_CYCLES < 1 || STROBE_CYCLES > 255 ||
      HOLD_CYCLES   < 1 || HOLD_CYCLES   > 255) begin : g_bad_timing
    $error("lamp_bus_master: SETUP/STROBE/HOLD_CYCLES must each be in 1..255");
  end

  lamp_bus_state_t  state;
  lamp_bus_state_t  state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_zero;
  logic             accept;
  logic             write_q;
  logic             write_next;
  logic             bus_phase_next;

  // One shared down-counter times all three phases; each phase reloads it on exit.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    cnt_zero   = (cnt == '0);
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
          cnt_next   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_next = ST_STROBE;
          cnt_next   = STROBE_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    write_next     = accept ? cmd_write : write_q;
    bus_phase_next = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                     (state_next == ST_HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Pin controls are registered from the next state so nothing on cmd_* reaches bus_* combinationally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      bus_rd      <= 1'b0;
      bus_wr      <= 1'b0;
      bus_data_oe <= 1'b0;
    end else begin
      cmd_ready   <= (state_next == ST_IDLE);
      rsp_valid   <= (state_next == ST_DONE);
      bus_rd      <= (state_next == ST_STROBE) && !write_next;
      bus_wr      <= (state_next == ST_STROBE) && write_next;
      bus_data_oe <= bus_phase_next && write_next;
    end
  end

  // Address/data pins double as the command latch and keep their last value between cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_q       <= 1'b0;
      bus_addr      <= '0;
      bus_test_addr <= 1'b1;
      bus_data_out  <= '0;
      rsp_data      <= '0;
    end else begin
      if (accept) begin
        write_q       <= cmd_write;
        bus_addr      <= cmd_addr;
        bus_test_addr <= cmd_test_addr;
        if (cmd_write) begin
          bus_data_out <= cmd_data;
        end
      end
      // Read data is taken unsynchronised on the last strobe clock; the bus guarantees it is settled.
      if (state == ST_STROBE && cnt_zero && !write_q) begin
        rsp_data <= bus_data_in;
      end else if (state == ST_HOLD && cnt_zero && write_q) begin
        rsp_data <= bus_data_out;
      end
    end
  end

endmodule

// File: tb/tb_lamp_bus_master.sv
// Directed bench for lamp_bus_master: default timing instance plus a 1/1/1 timing instance.
module tb_lamp_bus_master;

  logic       clock;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_test_addr;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data, bus_data_out, bus_data_in;
  logic       bus_data_oe, bus_test_addr, bus_rd, bus_wr;
  logic [2:0] bus_addr;

  logic       cmd_valid_1, cmd_ready_1, cmd_write_1, cmd_test_addr_1;
  logic [2:0] cmd_addr_1;
  logic [7:0] cmd_data_1;
  logic       rsp_valid_1;
  logic [7:0] rsp_data_1, bus_data_out_1, bus_data_in_1;
  logic       bus_data_oe_1, bus_test_addr_1, bus_rd_1, bus_wr_1;
  logic [2:0] bus_addr_1;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_wr, m_rd, m_oe, m_rv, m_rdy;
  logic [7:0]  t_rdata [0:31];
  logic [7:0]  t_dout  [0:31];
  logic [2:0]  t_addr  [0:31];
  logic        t_ta    [0:31];
  logic [7:0]  din     [0:31];
  logic [7:0]  d_tbl   [0:2];
  int          acc;

  lamp_bus_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_test_addr(cmd_test_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe), .bus_data_in(bus_data_in),
    .bus_addr(bus_addr), .bus_test_addr(bus_test_addr), .bus_rd(bus_rd), .bus_wr(bus_wr)
  );

  lamp_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1), .cmd_write(cmd_write_1),
    .cmd_addr(cmd_addr_1), .cmd_test_addr(cmd_test_addr_1), .cmd_data(cmd_data_1),
    .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1),
    .bus_data_out(bus_data_out_1), .bus_data_oe(bus_data_oe_1), .bus_data_in(bus_data_in_1),
    .bus_addr(bus_addr_1), .bus_test_addr(bus_test_addr_1), .bus_rd(bus_rd_1), .bus_wr(bus_wr_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_din(input logic [7:0] v);
    for (int i = 0; i < 32; i++) din[i] = v;
  endtask

  // Issues one command in the current (idle) period and records periods T+1..T+n at negedges.
  task automatic run(input logic w, input logic [2:0] a, input logic ta,
                     input logic [7:0] d, input int n);
    m_wr = '0; m_rd = '0; m_oe = '0; m_rv = '0; m_rdy = '0;
    cmd_write = w; cmd_addr = a; cmd_test_addr = ta; cmd_data = d; cmd_valid = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      m_wr[k] = bus_wr; m_rd[k] = bus_rd; m_oe[k] = bus_data_oe;
      m_rv[k] = rsp_valid; m_rdy[k] = cmd_ready;
      t_rdata[k] = rsp_data; t_dout[k] = bus_data_out;
      t_addr[k] = bus_addr; t_ta[k] = bus_test_addr;
      cmd_valid = 1'b0;
      bus_data_in = din[k];
    end
    bus_data_in = 8'hFF;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_test_addr = 1'b0; cmd_data = '0;
    cmd_valid_1 = 1'b0; cmd_write_1 = 1'b0; cmd_addr_1 = '0; cmd_test_addr_1 = 1'b0;
    cmd_data_1 = '0; bus_data_in_1 = 8'hFF;
    bus_data_in = 8'hFF;
    fill_din(8'hFF);

    @(negedge clock);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_data_out", 32'(bus_data_out), 0);
    chk("rst_oe", 32'(bus_data_oe), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_test_addr", 32'(bus_test_addr), 1);
    chk("rst_rd_wr", 32'({bus_rd, bus_wr}), 0);
    chk("rst1_ready", 32'(cmd_ready_1), 1);
    reset = 1'b0;
    @(negedge clock);

    // Write, default timing
    fill_din(8'hFF);
    run(1'b1, 3'd5, 1'b0, 8'hA5, 10);
    chk("wr_strobe_mask", m_wr, 32'h0000_0078);
    chk("wr_rd_mask", m_rd, 32'h0);
    chk("wr_oe_mask", m_oe, 32'h0000_01FE);
    chk("wr_rsp_valid_mask", m_rv, 32'h0000_0200);
    chk("wr_ready_mask", m_rdy, 32'h0000_0400);
    chk("wr_addr_t1", 32'(t_addr[1]), 5);
    chk("wr_addr_hold", 32'(t_addr[8]), 5);
    chk("wr_test_addr_t1", 32'(t_ta[1]), 0);
    chk("wr_data_out_t1", 32'(t_dout[1]), 32'hA5);
    chk("wr_rsp_data", 32'(t_rdata[9]), 32'hA5);

    // Read, data valid only during strobe
    fill_din(8'hFF);
    for (int k = 3; k <= 6; k++) din[k] = 8'h3C;
    run(1'b0, 3'd2, 1'b1, 8'h00, 10);
    chk("rd_strobe_mask", m_rd, 32'h0000_0078);
    chk("rd_wr_mask", m_wr, 32'h0);
    chk("rd_oe_mask", m_oe, 32'h0);
    chk("rd_rsp_valid_mask", m_rv, 32'h0000_0200);
    chk("rd_rsp_data", 32'(t_rdata[9]), 32'h3C);
    chk("rd_rsp_data_held", 32'(t_rdata[10]), 32'h3C);
    chk("rd_addr", 32'(t_addr[4]), 2);
    chk("rd_addr_idle_kept", 32'(t_addr[10]), 2);
    chk("rd_test_addr", 32'(t_ta[4]), 1);
    chk("rd_data_out_kept", 32'(t_dout[1]), 32'hA5);

    // Read whose data changes on the final strobe clock
    fill_din(8'hFF);
    for (int k = 3; k <= 5; k++) din[k] = 8'h11;
    din[6] = 8'h22;
    run(1'b0, 3'd7, 1'b0, 8'h00, 10);
    chk("rd_late_rsp_data", 32'(t_rdata[9]), 32'h22);

    // cmd_valid held high with three queued writes
    fill_din(8'hFF);
    d_tbl[0] = 8'h10; d_tbl[1] = 8'h20; d_tbl[2] = 8'h30;
    m_rv = '0; m_rdy = '0;
    chk("q_ready_start", 32'(cmd_ready), 1);
    cmd_write = 1'b1; cmd_addr = 3'd4; cmd_test_addr = 1'b1; cmd_data = d_tbl[0];
    cmd_valid = 1'b1;
    acc = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      m_rv[k] = rsp_valid; m_rdy[k] = cmd_ready; t_rdata[k] = rsp_data;
      if (cmd_ready) begin
        if (acc < 3) begin
          cmd_data = d_tbl[acc];
          acc++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    chk("q_accepts", acc, 3);
    chk("q_rsp_valid_mask", m_rv, 32'h2008_0200);
    chk("q_ready_mask", m_rdy, 32'h4010_0400);
    chk("q_rsp0", 32'(t_rdata[9]), 32'h10);
    chk("q_rsp1", 32'(t_rdata[19]), 32'h20);
    chk("q_rsp2", 32'(t_rdata[29]), 32'h30);

    // Reset pulse during strobe
    cmd_write = 1'b1; cmd_addr = 3'd6; cmd_test_addr = 1'b0; cmd_data = 8'hC3;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      cmd_valid = 1'b0;
    end
    chk("rst_mid_pre_wr", 32'(bus_wr), 1);
    chk("rst_mid_pre_oe", 32'(bus_data_oe), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(bus_wr), 0);
    chk("rst_mid_oe", 32'(bus_data_oe), 0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mid_ready", 32'(cmd_ready), 1);
    chk("rst_mid_addr", 32'(bus_addr), 0);
    chk("rst_mid_test_addr", 32'(bus_test_addr), 1);
    chk("rst_mid_data_out", 32'(bus_data_out), 0);
    chk("rst_mid_rsp_data", 32'(rsp_data), 0);
    @(negedge clock);
    reset = 1'b0;
    m_rv = '0; m_rdy = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      m_rv[k] = rsp_valid; m_rdy[k] = cmd_ready;
    end
    chk("rst_after_no_rsp", m_rv, 32'h0);
    chk("rst_after_ready", m_rdy, 32'h0000_1FFE);
    run(1'b1, 3'd1, 1'b0, 8'h77, 10);
    chk("rst_next_wr_mask", m_wr, 32'h0000_0078);
    chk("rst_next_rsp_valid_mask", m_rv, 32'h0000_0200);
    chk("rst_next_rsp_data", 32'(t_rdata[9]), 32'h77);

    // Minimum timing instance (S = W = H = 1)
    m_wr = '0; m_oe = '0; m_rv = '0; m_rdy = '0;
    cmd_write_1 = 1'b1; cmd_addr_1 = 3'd3; cmd_test_addr_1 = 1'b1; cmd_data_1 = 8'h5A;
    cmd_valid_1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      m_wr[k] = bus_wr_1; m_oe[k] = bus_data_oe_1; m_rv[k] = rsp_valid_1;
      m_rdy[k] = cmd_ready_1; t_rdata[k] = rsp_data_1; t_addr[k] = bus_addr_1;
      cmd_valid_1 = 1'b0;
    end
    chk("min_wr_mask", m_wr, 32'h0000_0004);
    chk("min_oe_mask", m_oe, 32'h0000_000E);
    chk("min_rsp_valid_mask", m_rv, 32'h0000_0010);
    chk("min_ready_mask", m_rdy, 32'h0000_0060);
    chk("min_rsp_data", 32'(t_rdata[4]), 32'h5A);
    chk("min_addr", 32'(t_addr[2]), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
